// File: rtl/uart_pkg.sv
// Shared UART definitions: baud default, data width, frame lengths and the
// serial FSM state encoding used by both uart_tx and uart_rx.
package uart_pkg;

    localparam int BAUD_DIV_DEFAULT = 434;
    localparam int DATA_W           = 8;
    localparam int FRAME_BITS_8N1   = 10;
    localparam int FRAME_BITS_8E1   = 11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Mod-DIV bit-period counter with synchronous clear; tick is high during the
// last clock of each period while enabled.
module uart_baud_tick #(
    parameter int DIV = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_r;

    assign tick = en & (cnt_r == LAST);

    // bit-period counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en) begin
            cnt_r <= tick ? '0 : cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 with a one-entry holding register for gapless frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module uart_tx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready,
    output logic              tx,
    output logic              busy
);

    uart_state_e       state_r, state_s;
    logic [DATA_W-1:0] hold_r;
    logic [DATA_W-1:0] shift_r, shift_s;
    logic [2:0]        bit_cnt_r, bit_cnt_s;
    logic              hold_full_r;
    logic              tx_r, tx_s;
    logic              drain_s;
    logic              accept_s;
    logic              tick_s;
`ifdef UART_TX_PARITY_EN
    logic              par_r, par_s;
`endif

    assign ready    = rst_n & ~hold_full_r;
    assign accept_s = valid_in & ready;
    assign busy     = (state_r != IDLE) | hold_full_r;
    assign tx       = tx_r;

    uart_baud_tick #(.DIV(BAUD_DIV)) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_r == IDLE),
        .en    (state_r != IDLE),
        .tick  (tick_s)
    );

    // next-state, shift and next tx level (tx is registered from tx_s)
    always_comb begin
        state_s   = state_r;
        shift_s   = shift_r;
        bit_cnt_s = bit_cnt_r;
        tx_s      = tx_r;
        drain_s   = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_s     = par_r;
`endif
        case (state_r)
            IDLE: begin
                if (hold_full_r) begin
                    drain_s = 1'b1;
                    shift_s = hold_r;
`ifdef UART_TX_PARITY_EN
                    par_s   = even_parity(hold_r);
`endif
                    state_s = START;
                    tx_s    = 1'b0;
                end else begin
                    tx_s    = 1'b1;
                end
            end
            START: begin
                if (tick_s) begin
                    state_s   = DATA;
                    bit_cnt_s = 3'd0;
                    tx_s      = shift_r[0];
                end else begin
                    tx_s      = 1'b0;
                end
            end
            DATA: begin
                if (tick_s) begin
                    if (bit_cnt_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_s = PARITY;
                        tx_s    = par_r;
`else
                        state_s = STOP;
                        tx_s    = 1'b1;
`endif
                    end else begin
                        shift_s   = {1'b0, shift_r[DATA_W-1:1]};
                        bit_cnt_s = bit_cnt_r + 3'd1;
                        tx_s      = shift_r[1];
                    end
                end else begin
                    tx_s = shift_r[0];
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick_s) begin
                    state_s = STOP;
                    tx_s    = 1'b1;
                end else begin
                    tx_s    = par_r;
                end
            end
`endif
            STOP: begin
                // a pending byte starts immediately, giving gapless frames
                if (tick_s && hold_full_r) begin
                    drain_s = 1'b1;
                    shift_s = hold_r;
`ifdef UART_TX_PARITY_EN
                    par_s   = even_parity(hold_r);
`endif
                    state_s = START;
                    tx_s    = 1'b0;
                end else if (tick_s) begin
                    state_s = IDLE;
                    tx_s    = 1'b1;
                end else begin
                    tx_s    = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
                tx_s    = 1'b1;
            end
        endcase
    end

    // FSM, shifter and tx registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            shift_r   <= '0;
            bit_cnt_r <= 3'd0;
            tx_r      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_r     <= 1'b0;
`endif
        end else begin
            state_r   <= state_s;
            shift_r   <= shift_s;
            bit_cnt_r <= bit_cnt_s;
            tx_r      <= tx_s;
`ifdef UART_TX_PARITY_EN
            par_r     <= par_s;
`endif
        end
    end

    // holding register; accept and drain are mutually exclusive via ready
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_full_r <= 1'b0;
            hold_r      <= '0;
        end else if (accept_s) begin
            hold_full_r <= 1'b1;
            hold_r      <= data_in;
        end else if (drain_s) begin
            hold_full_r <= 1'b0;
            hold_r      <= hold_r;
        end else begin
            hold_full_r <= hold_full_r;
            hold_r      <= hold_r;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame shape and timing against a bit-list
// model, back-to-back gapless frames, backpressure and mid-frame reset.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int DIV = 434;
`ifdef UART_TX_PARITY_EN
    localparam int NB = FRAME_BITS_8E1;
`else
    localparam int NB = FRAME_BITS_8N1;
`endif
    localparam int F = NB * DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid_in = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       ready, tx, busy;

    int tests_run = 0;
    int failed = 0;

    always #10 clk = ~clk;

    uart_tx #(.BAUD_DIV(DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .valid_in (valid_in),
        .ready    (ready),
        .tx       (tx),
        .busy     (busy)
    );

    // Expected line levels, index 0 = first bit on the wire
    function automatic logic [NB-1:0] model_frame(input logic [7:0] b);
        logic [NB-1:0] f;
        int ones;
        f = '0;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = ((int'(b) >> i) % 2) == 1;
            ones += (int'(b) >> i) % 2;
        end
`ifdef UART_TX_PARITY_EN
        f[9] = (ones % 2) == 1;
`endif
        f[NB-1] = 1'b1;
        return f;
    endfunction

    // Samples NB bit periods starting at the next falling edge
    task automatic capture_frame(output logic [NB-1:0] bits, output int glitches);
        bits = '0;
        glitches = 0;
        for (int i = 0; i < NB; i++) begin
            for (int c = 0; c < DIV; c++) begin
                @(negedge clk);
                if (c == 0) bits[i] = tx;
                else if (tx !== bits[i]) glitches++;
            end
        end
    endtask

    // Waits (bounded) for ready, then handshakes one byte; returns just after the accept edge
    task automatic send(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        for (int w = 0; w < 3 * F && !ok; w++) begin
            @(negedge clk);
            if (ready === 1'b1) ok = 1'b1;
        end
        tests_run++;
        if (!ok) begin
            failed++;
            $display("FAIL send_timeout: ready=%b required 1 byte=%02h", ready, b);
        end else begin
            data_in = b;
            valid_in = 1'b1;
            @(posedge clk);
            #1 valid_in = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++; if (tx !== 1'b1)    begin failed++; $display("FAIL reset_tx: got %b required 1", tx); end
        tests_run++; if (ready !== 1'b0) begin failed++; $display("FAIL reset_ready: got %b required 0", ready); end
        tests_run++; if (busy !== 1'b0)  begin failed++; $display("FAIL reset_busy: got %b required 0", busy); end
        rst_n = 1'b1;
        #1;
        tests_run++; if (ready !== 1'b1) begin failed++; $display("FAIL release_ready: got %b required 1", ready); end
        tests_run++; if (busy !== 1'b0)  begin failed++; $display("FAIL release_busy: got %b required 0", busy); end
    endtask

    task automatic test_single_byte(input logic [7:0] b);
        logic [NB-1:0] f;
        int g;
        send(b);
        @(negedge clk);
        tests_run++;
        if (tx !== 1'b1 || busy !== 1'b1) begin
            failed++; $display("FAIL latency_pending: tx=%b busy=%b required tx=1 busy=1", tx, busy);
        end
        @(posedge clk);
        capture_frame(f, g);
        tests_run++; if (f !== model_frame(b)) begin failed++; $display("FAIL frame_%02h: got %b required %b", b, f, model_frame(b)); end
        tests_run++; if (g !== 0) begin failed++; $display("FAIL bit_width_%02h: got %0d off-level samples required 0", b, g); end
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            failed++; $display("FAIL after_stop_%02h: busy=%b tx=%b required busy=0 tx=1", b, busy, tx);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [NB-1:0] f;
        int g;
        logic [7:0] pb [2];
        logic       pe [2];
        pb[0] = 8'h41; pe[0] = 1'b0;
        pb[1] = 8'h07; pe[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            send(pb[i]);
            @(posedge clk);
            capture_frame(f, g);
            tests_run++; if (f[9] !== pe[i]) begin failed++; $display("FAIL parity_%02h: got %b required %b", pb[i], f[9], pe[i]); end
            tests_run++; if (f !== model_frame(pb[i]) || g !== 0) begin failed++; $display("FAIL parity_frame_%02h: got %b glitches %0d required %b", pb[i], f, g, model_frame(pb[i])); end
            @(negedge clk);
            tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL parity_len_%02h: busy=%b required 0", pb[i], busy); end
        end
    endtask
`endif

    task automatic test_back_to_back();
        logic [NB-1:0] f1, f2;
        int g1, g2, bad;
        send(8'h55);
        @(posedge clk);
        fork
            begin
                capture_frame(f1, g1);
                capture_frame(f2, g2);
            end
            begin
                @(negedge clk);
                tests_run++; if (ready !== 1'b1) begin failed++; $display("FAIL b2b_second_ready: got %b required 1", ready); end
                data_in = 8'hA3;
                valid_in = 1'b1;
                @(posedge clk);
                #1 valid_in = 1'b0;
                bad = 0;
                repeat (F - 1) begin
                    @(negedge clk);
                    if (ready !== 1'b0) bad++;
                end
                tests_run++; if (bad !== 0) begin failed++; $display("FAIL b2b_ready_low: got %0d cycles high required 0", bad); end
                @(negedge clk);
                tests_run++; if (ready !== 1'b1) begin failed++; $display("FAIL b2b_ready_free: got %b required 1", ready); end
            end
        join
        tests_run++; if (f1 !== model_frame(8'h55) || g1 !== 0) begin failed++; $display("FAIL b2b_frame1: got %b glitches %0d required %b", f1, g1, model_frame(8'h55)); end
        tests_run++; if (f2 !== model_frame(8'hA3) || g2 !== 0) begin failed++; $display("FAIL b2b_frame2: got %b glitches %0d required %b", f2, g2, model_frame(8'hA3)); end
        @(negedge clk);
        tests_run++; if (busy !== 1'b0 || tx !== 1'b1) begin failed++; $display("FAIL b2b_end: busy=%b tx=%b required busy=0 tx=1", busy, tx); end
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        send(8'hA5);
        @(posedge clk);
        send(8'hC3);
        repeat (4 * DIV + DIV / 2 - 1) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (tx !== 1'b0 || busy !== 1'b1 || ready !== 1'b0) begin
            failed++; $display("FAIL mid_bit3: tx=%b busy=%b ready=%b required tx=0 busy=1 ready=0", tx, busy, ready);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        tests_run++; if (tx !== 1'b1) begin failed++; $display("FAIL mid_reset_tx: got %b required 1", tx); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests_run++; if (ready !== 1'b1 || busy !== 1'b0) begin failed++; $display("FAIL mid_release: ready=%b busy=%b required ready=1 busy=0", ready, busy); end
        bad = 0;
        repeat (12 * DIV) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        tests_run++; if (bad !== 0) begin failed++; $display("FAIL mid_no_resume: got %0d active cycles required 0", bad); end
    endtask

    task automatic test_idle_backpressure();
        logic [NB-1:0] f;
        int g, bad;
        bad = 0;
        repeat (10 * DIV) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        tests_run++; if (bad !== 0) begin failed++; $display("FAIL idle_quiet: got %0d active cycles required 0", bad); end
        send(8'h12);
        tests_run++; if (ready !== 1'b0) begin failed++; $display("FAIL bp_ready: got %b required 0", ready); end
        data_in = 8'hFF;
        valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        capture_frame(f, g);
        tests_run++; if (f !== model_frame(8'h12) || g !== 0) begin failed++; $display("FAIL bp_frame: got %b glitches %0d required %b", f, g, model_frame(8'h12)); end
        bad = 0;
        repeat (F + DIV) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        tests_run++; if (bad !== 0) begin failed++; $display("FAIL bp_no_extra: got %0d active cycles required 0", bad); end
    endtask

    task automatic test_random();
        logic [7:0] b;
        for (int n = 0; n < 5; n++) begin
            b = 8'($urandom);
            repeat ($urandom_range(0, 20)) @(posedge clk);
            test_single_byte(b);
        end
    endtask

    initial begin
        #(20ns * 100000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_byte(8'h41);
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_back_to_back();
        test_reset_mid_frame();
        test_idle_backpressure();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter, the counterpart of uart_rx on the same 50 MHz clock domain. Serialises bytes as 8N1 frames: start bit, 8 data bits LSB first, stop bit. Accepts bytes over a valid/ready handshake into a one-entry holding register, so consecutive frames go out back-to-back with no idle gap. Drives the tx line that feeds the link and loops back to uart_rx in system benches.

Parameters:
BAUD_DIV, 434, clocks per UART bit (50 MHz / 115200); legal range >= 2
DATA_W, 8, data bits per frame; fixed at 8 for this block

Ports:
clk  input  1  system clock, 50 MHz
rst_n  input  1  reset; synchronous, active-low
data_in  input  8  byte to send; sampled only on the handshake
valid_in  input  1  data_in is valid
ready  output  1  holding register can accept a byte
tx  output  1  serial line; idle high; registered
busy  output  1  frame in progress or byte pending

Behaviour:
- Reset, sampled at clk edge while rst_n=0: tx=1, hold_full=0, FSM=IDLE, baud_cnt=0, bit_cnt=0.
- ready = rst_n & ~hold_full (combinational). So ready=0 during reset and 1 after release.
- busy = (state != IDLE) | hold_full. busy is 0 out of reset.
- Handshake: a byte is accepted at an edge where valid_in & ready. data_in is copied to the holding register and hold_full is set.
- valid_in without ready has no effect. valid_in may drop without the byte being taken.
- FSM states: IDLE, START, DATA, PARITY (only with the optional feature), STOP.
- Each non-IDLE state holds exactly BAUD_DIV clocks:
  - baud_cnt counts 0..BAUD_DIV-1.
  - The state advances on the edge where baud_cnt = BAUD_DIV-1.
- IDLE, hold_full=1 at an edge:
  - Load the shift register from the holding register and clear hold_full.
  - Enter START; tx=0 from that edge.
- Latency: a handshake at edge k gives hold_full=1 after k and tx=0 after edge k+1.
- START -> DATA.
- DATA: tx = shift[0]; shift right at each bit end. bit_cnt runs 0..7. After bit 7, go to STOP (or PARITY).
- STOP: tx=1. At the end of STOP:
  - If hold_full=1, reload the shift register and go directly to START. No idle cycle; back-to-back frames are exactly 10*BAUD_DIV clocks apart.
  - Otherwise go to IDLE.
- Draining the holding register on an edge frees ready from the next cycle. Accept and drain cannot coincide, because ready=0 whenever hold_full=1.
- A new byte may be accepted at any time the holding register is empty, including mid-frame. The frame in flight is never disturbed.
- Reset mid-frame:
  - The frame is aborted and tx=1 after the reset edge.
  - Any pending byte is discarded.
  - No partial frame resumes after release.
- tx is always driven from a flop (glitch-free).

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: a PARITY state of BAUD_DIV clocks is inserted between bit 7 and STOP. tx = even parity (XOR of the 8 data bits). Frame is 11*BAUD_DIV clocks.
- Undefined: no PARITY state, no parity logic; 8N1 frame of 10*BAUD_DIV clocks.

Decomposition:
- Shared package uart_pkg: BAUD_DIV default (434), DATA_W (8), and the FSM state enum (IDLE/START/DATA/PARITY/STOP) shared with uart_rx. Also the frame-length constants FRAME_BITS_8N1=10 and FRAME_BITS_8E1=11.
- One natural sub-module: uart_baud_tick. It is a mod-BAUD_DIV counter with a sync clear and a one-cycle tick output, reusable by uart_rx.

Test Plan:
- Single byte: send 0x41 with BAUD_DIV=434 -> tx sequence 0,1,0,0,0,0,0,1,0,1, each bit exactly 8680 ns. busy=0 and tx=1 after the stop bit.
- Loopback: drive uart_tx tx into uart_rx rx and send 0x41 then 0x35 -> uart_rx pulses valid with data_out=0x41, then 0x35.
- Back-to-back: handshake 0x55 and 0xA3 on consecutive opportunities.
  - ready=0 after the second accept until frame 1 ends.
  - The stop bit of frame 1 is followed immediately by the start bit of frame 2.
  - Total is 8680 clocks.
- Reset mid-frame: pull rst_n low for 2 clocks during data bit 3 with a byte pending.
  - tx=1 after the reset edge; ready=1 and busy=0 after release.
  - No further frame is sent.
- Idle and backpressure: valid_in=0 for 10 bit periods -> tx stays 1 and busy=0. valid_in pulsed while ready=0 -> byte ignored, no extra frame.
- Parity (UART_TX_PARITY_EN defined): 0x41 -> parity bit 0; 0x07 -> parity bit 1. Frame length is 11*434 clocks.
